// File: rtl/vx_mem_rsp_arb_pkg.sv
// Shared types and helpers for the memory-response arbiter.
package vx_mem_rsp_arb_pkg;

  localparam int unsigned PERF_CNT_WIDTH = 32;

  // Wide enough for any supported tag plus up to 4 index bits.
  localparam int unsigned PACK_WIDTH = 64;

  // Index bits appended to the tag; no index field at all for a single source.
  function automatic int unsigned log_num_reqs(input int unsigned n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Physical width of index signals; at least one bit so vectors stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [PACK_WIDTH-1:0] pack_tag(input logic [PACK_WIDTH-1:0] tag,
                                                     input logic [PACK_WIDTH-1:0] idx,
                                                     input int unsigned           idx_bits);
    logic [PACK_WIDTH-1:0] mask;
    mask = (PACK_WIDTH'(1) << idx_bits) - PACK_WIDTH'(1);
    return (tag << idx_bits) | (idx & mask);
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping.
module vx_rr_arbiter #(
  parameter int unsigned NUM_REQS  = 4,
  parameter int unsigned IDX_WIDTH = 2
) (
  input  logic [NUM_REQS-1:0]  requests_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  input  logic                 enable_i,
  output logic [NUM_REQS-1:0]  grant_onehot_o,
  output logic [IDX_WIDTH-1:0] grant_index_o
);

  logic found;
  int   pos;

  always_comb begin
    found          = 1'b0;
    pos            = 0;
    grant_index_o  = '0;
    grant_onehot_o = '0;
    for (int k = 0; k < int'(NUM_REQS); k++) begin
      pos = (int'(ptr_i) + k) % int'(NUM_REQS);
      if (!found && requests_i[pos]) begin
        found         = 1'b1;
        grant_index_o = IDX_WIDTH'(pos);
      end
    end
    // The index is still reported when disabled; only the one-hot is gated.
    if (enable_i && found) begin
      grant_onehot_o[grant_index_o] = 1'b1;
    end
  end

endmodule

// File: rtl/vx_mem_rsp_arb.sv
// Round-robin merge of NUM_REQS response channels into one registered output.
// Optional stall counter output enabled by defining VX_MEM_RSP_ARB_PERF_EN.
module vx_mem_rsp_arb
  import vx_mem_rsp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS      = 4,
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned TAG_IN_WIDTH  = 8,
  parameter int unsigned LOG_NUM_REQS  = log_num_reqs(NUM_REQS),
  parameter int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              rsp_in_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   rsp_in_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] rsp_in_tag,
  output logic [NUM_REQS-1:0]              rsp_in_ready,
  output logic                             rsp_out_valid,
  output logic [DATA_WIDTH-1:0]            rsp_out_data,
  output logic [TAG_OUT_WIDTH-1:0]         rsp_out_tag,
  input  logic                             rsp_out_ready
`ifdef VX_MEM_RSP_ARB_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0]        perf_stall_cycles
`endif
);

  localparam int unsigned IdxWidth = idx_width(NUM_REQS);

  logic [NUM_REQS-1:0]      grant_onehot;
  logic [IdxWidth-1:0]      grant_index;
  logic [IdxWidth-1:0]      ptr_q, ptr_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [TAG_OUT_WIDTH-1:0] out_tag_q, out_tag_d;
  logic [DATA_WIDTH-1:0]    win_data;
  logic [TAG_IN_WIDTH-1:0]  win_tag;
  logic                     any_valid;
  logic                     stage_free;
  logic                     accept;

  assign any_valid  = |rsp_in_valid;
  assign stage_free = !out_valid_q || rsp_out_ready;
  // Ready must read zero for the whole time reset is held, not just after an edge.
  assign accept     = any_valid && stage_free && !reset;

  vx_rr_arbiter #(
    .NUM_REQS  (NUM_REQS),
    .IDX_WIDTH (IdxWidth)
  ) u_rr_arbiter (
    .requests_i     (rsp_in_valid),
    .ptr_i          (ptr_q),
    .enable_i       (stage_free && !reset),
    .grant_onehot_o (grant_onehot),
    .grant_index_o  (grant_index)
  );

  assign rsp_in_ready = grant_onehot;
  assign win_data     = rsp_in_data[int'(grant_index)*DATA_WIDTH +: DATA_WIDTH];
  assign win_tag      = rsp_in_tag[int'(grant_index)*TAG_IN_WIDTH +: TAG_IN_WIDTH];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_tag_d   = TAG_OUT_WIDTH'(pack_tag(PACK_WIDTH'(win_tag), PACK_WIDTH'(grant_index),
                                            LOG_NUM_REQS));
      if (int'(grant_index) == int'(NUM_REQS) - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_index + 1'b1;
      end
    end else if (out_valid_q && rsp_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_out_valid = out_valid_q;
  assign rsp_out_data  = out_data_q;
  assign rsp_out_tag   = out_tag_q;

`ifdef VX_MEM_RSP_ARB_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !rsp_out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_vx_mem_rsp_arb.sv
// Directed bench for vx_mem_rsp_arb with a cycle-level reference model and literal checks.
module tb_vx_mem_rsp_arb;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int TW  = 8;
  localparam int TOW = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     in_valid = '0;
  logic [NR*DW-1:0]  in_data = '0;
  logic [NR*TW-1:0]  in_tag = '0;
  logic [NR-1:0]     in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [TOW-1:0]    out_tag;
  logic              out_ready = 1'b0;
`ifdef VX_MEM_RSP_ARB_PERF_EN
  logic [31:0]       perf_stall;
`endif

  always #5 clk = ~clk;

  vx_mem_rsp_arb #(
    .NUM_REQS     (NR),
    .DATA_WIDTH   (DW),
    .TAG_IN_WIDTH (TW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rsp_in_valid      (in_valid),
    .rsp_in_data       (in_data),
    .rsp_in_tag        (in_tag),
    .rsp_in_ready      (in_ready),
    .rsp_out_valid     (out_valid),
    .rsp_out_data      (out_data),
    .rsp_out_tag       (out_tag),
    .rsp_out_ready     (out_ready)
`ifdef VX_MEM_RSP_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-source pending responses, each {tag, data}.
  logic [TW+DW-1:0] srcq [NR][$];
  logic [TOW-1:0]   out_log [$];

  // Reference model state: output slot contents, rr pointer, stall count.
  logic           m_valid = 1'b0;
  logic [DW-1:0]  m_data = '0;
  logic [TOW-1:0] m_tag = '0;
  int             m_ptr = 0;
  int             acc = -1;
  logic [31:0]    m_stall = '0;

  function automatic int first_valid(input int p);
    for (int k = 0; k < NR; k++) begin
      if (in_valid[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] r;
    int g;
    r = '0;
    g = first_valid(m_ptr);
    if (!reset && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    int g;
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_tag   <= '0;
      m_ptr   <= 0;
      acc     <= -1;
      m_stall <= '0;
    end else begin
      g = first_valid(m_ptr);
      acc <= -1;
      if (m_valid && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 1;
      if ((!m_valid || out_ready) && g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= in_data[g*DW +: DW];
        m_tag   <= {in_tag[g*TW +: TW], 2'(g)};
        m_ptr   <= (g + 1) % NR;
        acc     <= g;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
    end else begin
      check("in_ready", 64'(in_ready), 64'(exp_ready()));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_tag", 64'(out_tag), 64'(m_tag));
      end
      if (out_valid && out_ready) out_log.push_back(out_tag);
    end
`ifdef VX_MEM_RSP_ARB_PERF_EN
    check("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
  end

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      if (srcq[i].size() > 0) begin
        in_valid[i]          = 1'b1;
        in_tag[i*TW +: TW]   = srcq[i][0][TW+DW-1:DW];
        in_data[i*DW +: DW]  = srcq[i][0][DW-1:0];
      end else begin
        in_valid[i]          = 1'b0;
        in_tag[i*TW +: TW]   = '0;
        in_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic push(input int i, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    srcq[i].push_back({tag, data});
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NR; i++) srcq[i].delete();
    refresh();
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (acc >= 0) void'(srcq[acc].pop_front());
    refresh();
  endtask

  function automatic bit busy();
    for (int i = 0; i < NR; i++) if (srcq[i].size() > 0) return 1'b1;
    return m_valid;
  endfunction

  task automatic run_idle(output int n);
    n = 0;
    while (busy() && n < 200) begin
      cycle();
      n++;
    end
    check("drain_budget", 64'(n < 200), 64'(1));
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_srcs();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_log.delete();
  endtask

  initial begin
    int n;
    // Reset state.
    @(negedge clk);
    check("lit_reset_valid", 64'(out_valid), 64'(0));
    check("lit_reset_ready", 64'(in_ready), 64'(0));
    reset_dut();

    // Single source 2.
    push(2, 8'h11, 32'hAB);
    refresh();
    cycle();
    @(negedge clk);
    check("lit_single_valid", 64'(out_valid), 64'(1));
    check("lit_single_data", 64'(out_data), 64'hAB);
    check("lit_single_tag", 64'(out_tag), 64'h46);
    run_idle(n);

    // All four continuously valid: 0,1,2,3,0,1,2,3 back to back.
    reset_dut();
    for (int k = 0; k < 8; k++) push(k % 4, 8'((k < 4 ? 8'h10 : 8'h20) + k % 4), 32'(k * 7 + 1));
    refresh();
    run_idle(n);
    check("lit_all4_cycles", 64'(n), 64'(9));
    check("lit_all4_count", 64'(out_log.size()), 64'(8));
    for (int k = 0; k < 8 && k < out_log.size(); k++)
      check("lit_all4_tag", 64'(out_log[k]),
            64'(((k < 4 ? 32'h10 : 32'h20) + k % 4) * 4 + k % 4));

    // Backpressure with sources 1 and 3.
    reset_dut();
    out_ready = 1'b0;
    push(1, 8'h31, 32'h1111);
    push(3, 8'h33, 32'h3333);
    refresh();
    cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("lit_bp_ready", 64'(in_ready), 64'(0));
      check("lit_bp_tag", 64'(out_tag), 64'hC5);
      check("lit_bp_data", 64'(out_data), 64'h1111);
      cycle();
    end
    out_ready = 1'b1;
    run_idle(n);
    check("lit_bp_count", 64'(out_log.size()), 64'(2));
    if (out_log.size() == 2) begin
      check("lit_bp_first", 64'(out_log[0]), 64'hC5);
      check("lit_bp_second", 64'(out_log[1]), 64'hCF);
    end

    // Pointer wraps after source 3, so source 0 beats source 3.
    reset_dut();
    push(3, 8'h03, 32'h3);
    refresh();
    run_idle(n);
    push(0, 8'h40, 32'h40);
    push(3, 8'h43, 32'h43);
    refresh();
    run_idle(n);
    check("lit_fair_count", 64'(out_log.size()), 64'(3));
    if (out_log.size() == 3) begin
      check("lit_fair_0", 64'(out_log[0]), 64'h00F);
      check("lit_fair_1", 64'(out_log[1]), 64'h100);
      check("lit_fair_2", 64'(out_log[2]), 64'h10F);
    end

    // Async reset while stalled, then pointer back at 0.
    reset_dut();
    out_ready = 1'b0;
    push(1, 8'h51, 32'h51);
    refresh();
    cycle();
    @(negedge clk);
    check("lit_ar_valid_before", 64'(out_valid), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("lit_ar_valid", 64'(out_valid), 64'(0));
    check("lit_ar_ready", 64'(in_ready), 64'(0));
    check("lit_ar_tag", 64'(out_tag), 64'(0));
    clear_srcs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    out_log.delete();
    push(0, 8'h60, 32'h60);
    push(2, 8'h62, 32'h62);
    refresh();
    run_idle(n);
    check("lit_ar_count", 64'(out_log.size()), 64'(2));
    if (out_log.size() == 2) begin
      check("lit_ar_first", 64'(out_log[0]), 64'h180);
      check("lit_ar_second", 64'(out_log[1]), 64'h18A);
    end

`ifdef VX_MEM_RSP_ARB_PERF_EN
    // Seven stalled cycles from a fresh reset.
    reset_dut();
    out_ready = 1'b0;
    push(0, 8'h70, 32'h70);
    refresh();
    repeat (8) cycle();
    @(negedge clk);
    check("lit_perf_7", 64'(perf_stall), 64'(7));
    out_ready = 1'b1;
    run_idle(n);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
